// File: rtl/instruction_store_if.sv
// Fetch port and host byte-loader port of the instruction store, grouped as one bundle.
// master = core/host side, slave = instruction_store.
interface instruction_store_if #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 26
);
   logic [15:0]            instructionPointer;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   instrValid;
   logic                   running;
   logic                   loadStart;
   logic                   loadEnd;
   logic [7:0]             loadByte;
   logic                   loadValid;
   logic                   loadReady;
   logic [ADDR_WIDTH:0]    wordCount;
   logic                   loadError;
   logic [7:0]             loadChecksum;

   modport master (
      output instructionPointer, loadStart, loadEnd, loadByte, loadValid,
      input  instruction, instrValid, running, loadReady, wordCount, loadError, loadChecksum
   );

   modport slave (
      input  instructionPointer, loadStart, loadEnd, loadByte, loadValid,
      output instruction, instrValid, running, loadReady, wordCount, loadError, loadChecksum
   );
endinterface

// File: rtl/instruction_store.sv
// Program memory with a byte-stream loader and a 1-cycle registered fetch port.
// Optional feature: define INSTR_STORE_CHECKSUM_EN to enable the XOR checksum of loaded bytes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | after reset, nothing loaded, fetches return 0/invalid
// ST_LOAD | accepting host bytes, packing 4 bytes per instruction word
// ST_RUN  | answering fetches for addresses below wordCount
module instruction_store #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 26
) (
   input  logic                 clock,
   input  logic                 resetN,
   instruction_store_if.slave   bus
);
   localparam int DEPTH   = 2 ** ADDR_WIDTH;
   localparam int SHIFT_W = INSTR_WIDTH - 8;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH:0]    word_count_q, word_count_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [SHIFT_W-1:0]     shift_q, shift_d;
   logic                   load_error_q, load_error_d;
   logic [INSTR_WIDTH-1:0] instruction_q, instruction_d;
   logic                   instr_valid_q, instr_valid_d;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic                   wr_en;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [INSTR_WIDTH-1:0] wr_data;
   logic                   load_ready;
   logic                   accept;
   logic                   fetch_hit;

   assign load_ready = (state_q == ST_LOAD) && !word_count_q[ADDR_WIDTH];
   assign accept     = bus.loadValid && load_ready;
   // loadStart kills the fetch on its own edge so instruction clears together with running
   assign fetch_hit  = (state_q == ST_RUN) && !bus.loadStart &&
                       (bus.instructionPointer < 16'(word_count_q));

   always_comb begin
      state_d       = state_q;
      word_count_d  = word_count_q;
      byte_idx_d    = byte_idx_q;
      shift_d       = shift_q;
      load_error_d  = load_error_q;
      wr_en         = 1'b0;
      wr_addr       = word_count_q[ADDR_WIDTH-1:0];
      wr_data       = {shift_q, bus.loadByte};
      instruction_d = '0;
      instr_valid_d = fetch_hit;
      if (fetch_hit) begin
         instruction_d = mem[bus.instructionPointer[ADDR_WIDTH-1:0]];
      end

      if (bus.loadStart) begin
         state_d      = ST_LOAD;
         word_count_d = '0;
         byte_idx_d   = '0;
         load_error_d = 1'b0;
      end else if (state_q == ST_LOAD) begin
         if (bus.loadValid && !load_ready) begin
            load_error_d = 1'b1;
         end
         if (accept) begin
            if (byte_idx_q == 2'd3) begin
               wr_en        = 1'b1;
               word_count_d = word_count_q + 1'b1;
               byte_idx_d   = 2'd0;
            end else begin
               // older bytes shift up; byte0's upper bits fall off the top
               shift_d    = {shift_q[SHIFT_W-9:0], bus.loadByte};
               byte_idx_d = byte_idx_q + 2'd1;
            end
         end
         if (bus.loadEnd) begin
            state_d = ST_RUN;
            if (byte_idx_d != 2'd0) begin
               load_error_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q       <= ST_IDLE;
         word_count_q  <= '0;
         byte_idx_q    <= '0;
         shift_q       <= '0;
         load_error_q  <= 1'b0;
         instruction_q <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         word_count_q  <= word_count_d;
         byte_idx_q    <= byte_idx_d;
         shift_q       <= shift_d;
         load_error_q  <= load_error_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

`ifdef INSTR_STORE_CHECKSUM_EN
   logic [7:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (bus.loadStart) begin
         checksum_d = '0;
      end else if (accept) begin
         checksum_d = checksum_q ^ bus.loadByte;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign bus.loadChecksum = checksum_q;
`else
   assign bus.loadChecksum = 8'h00;
`endif

   assign bus.instruction = instruction_q;
   assign bus.instrValid  = instr_valid_q;
   assign bus.running     = (state_q == ST_RUN);
   assign bus.loadReady   = load_ready;
   assign bus.wordCount   = word_count_q;
   assign bus.loadError   = load_error_q;
endmodule

// File: tb/tb_instruction_store.sv
// Self-checking bench for instruction_store: directed scenarios plus randomized loads/fetches
// compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_instruction_store;
   localparam int AW    = 8;
   localparam int IW    = 26;
   localparam int DEPTH = 2 ** AW;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

   logic clock  = 1'b0;
   logic resetN = 1'b0;
   always #5 clock = ~clock;

   instruction_store_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();
   instruction_store #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int          m_mode;
   int unsigned m_cnt;
   bit [7:0]    m_pend [$];
   bit          m_err;
   bit [7:0]    m_chk;
   bit [IW-1:0] m_mem [DEPTH];
   bit [IW-1:0] e_instr;
   bit          e_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_cnt   = 0;
      m_pend.delete();
      m_err   = 1'b0;
      m_chk   = 8'h00;
      e_instr = '0;
      e_valid = 1'b0;
   endtask

   task automatic check_outputs(input string ctx);
      bit [7:0] exp_chk;
`ifdef INSTR_STORE_CHECKSUM_EN
      exp_chk = m_chk;
`else
      exp_chk = 8'h00;
`endif
      check({ctx, ".instruction"}, 32'(bus.instruction), 32'(e_instr));
      check({ctx, ".instrValid"},  32'(bus.instrValid), 32'(e_valid));
      check({ctx, ".running"},     32'(bus.running), 32'(m_mode == M_RUN));
      check({ctx, ".loadReady"},   32'(bus.loadReady), 32'(m_mode == M_LOAD && m_cnt < DEPTH));
      check({ctx, ".wordCount"},   32'(bus.wordCount), m_cnt);
      check({ctx, ".loadError"},   32'(bus.loadError), 32'(m_err));
      check({ctx, ".loadChecksum"}, 32'(bus.loadChecksum), 32'(exp_chk));
   endtask

   // One clock: update the model from the inputs presented at this edge, then compare.
   task automatic step(input string ctx);
      @(posedge clock);
      if (m_mode == M_RUN && !bus.loadStart && 32'(bus.instructionPointer) < m_cnt) begin
         e_instr = m_mem[bus.instructionPointer[AW-1:0]];
         e_valid = 1'b1;
      end else begin
         e_instr = '0;
         e_valid = 1'b0;
      end
      if (bus.loadStart) begin
         m_mode = M_LOAD;
         m_cnt  = 0;
         m_pend.delete();
         m_err  = 1'b0;
         m_chk  = 8'h00;
      end else if (m_mode == M_LOAD) begin
         if (bus.loadValid) begin
            if (m_cnt < DEPTH) begin
               m_chk ^= bus.loadByte;
               m_pend.push_back(bus.loadByte);
               if (m_pend.size() == 4) begin
                  m_mem[m_cnt] = {m_pend[0][1:0], m_pend[1], m_pend[2], m_pend[3]};
                  m_cnt++;
                  m_pend.delete();
               end
            end else begin
               m_err = 1'b1;
            end
         end
         if (bus.loadEnd) begin
            m_mode = M_RUN;
            if (m_pend.size() != 0) m_err = 1'b1;
         end
      end
      #1;
      check_outputs(ctx);
   endtask

   task automatic idle_inputs();
      bus.loadStart = 1'b0;
      bus.loadEnd   = 1'b0;
      bus.loadValid = 1'b0;
      bus.loadByte  = 8'h00;
   endtask

   task automatic pulse_start();
      bus.loadStart = 1'b1;
      step("start");
      bus.loadStart = 1'b0;
   endtask

   task automatic pulse_end();
      bus.loadEnd = 1'b1;
      step("end");
      bus.loadEnd = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.loadValid = 1'b1;
      bus.loadByte  = b;
      step("byte");
      bus.loadValid = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] ip);
      bus.instructionPointer = ip;
      step("fetch");
   endtask

   initial begin
      logic [7:0] prog8 [8];
      int nb;
      idle_inputs();
      bus.instructionPointer = 16'h0;
      model_reset();
      #22;
      check_outputs("reset");
      @(negedge clock);
      resetN = 1'b1;

      // Two-word program, then fetch 0,1,2
      prog8 = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h11, 8'h22, 8'h33};
      pulse_start();
      foreach (prog8[i]) send_byte(prog8[i]);
      pulse_end();
      check("basic.wordCount", 32'(bus.wordCount), 32'd2);
      check("basic.loadError", 32'(bus.loadError), 32'd0);
      fetch(16'd0);
      check("basic.w0", 32'(bus.instruction), 32'h03AABBCC);
      check("basic.v0", 32'(bus.instrValid), 32'd1);
      fetch(16'd1);
      check("basic.w1", 32'(bus.instruction), 32'h01112233);
      fetch(16'd2);
      check("basic.w2", 32'(bus.instruction), 32'd0);
      check("basic.v2", 32'(bus.instrValid), 32'd0);

      // Byte0 upper bits are dropped
      pulse_start();
      send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
`ifdef INSTR_STORE_CHECKSUM_EN
      check("ff.checksum", 32'(bus.loadChecksum), 32'hFE);
`endif
      pulse_end();
      fetch(16'd0);
      check("ff.word", 32'(bus.instruction), 32'h03000001);

      // Partial final word
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(8'($urandom));
      pulse_end();
      check("partial.wordCount", 32'(bus.wordCount), 32'd1);
      check("partial.loadError", 32'(bus.loadError), 32'd1);
      check("partial.running", 32'(bus.running), 32'd1);
      fetch(16'd1);
      check("partial.v1", 32'(bus.instrValid), 32'd0);

      // Fill memory with loadValid held, then overflow
      pulse_start();
      bus.loadValid = 1'b1;
      for (int i = 0; i < DEPTH * 4 + 4; i++) begin
         bus.loadByte = 8'($urandom);
         step("fill");
         if (i == DEPTH * 4 - 1) begin
            check("fill.loadReady", 32'(bus.loadReady), 32'd0);
            check("fill.wordCount", 32'(bus.wordCount), 32'(DEPTH));
            check("fill.noerr", 32'(bus.loadError), 32'd0);
         end
         if (i == DEPTH * 4) check("fill.overflow", 32'(bus.loadError), 32'd1);
      end
      bus.loadValid = 1'b0;
      pulse_end();
      fetch(16'(DEPTH - 1));
      check("fill.last", 32'(bus.instrValid), 32'd1);
      fetch(16'(DEPTH));
      check("fill.beyond", 32'(bus.instrValid), 32'd0);
      pulse_start();
      check("fill.clrerr", 32'(bus.loadError), 32'd0);
      check("fill.clrcnt", 32'(bus.wordCount), 32'd0);

      // loadStart and loadEnd together while running
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      pulse_end();
      fetch(16'd0);
      check("both.prevalid", 32'(bus.instrValid), 32'd1);
      bus.loadStart = 1'b1;
      bus.loadEnd   = 1'b1;
      step("both");
      idle_inputs();
      check("both.running", 32'(bus.running), 32'd0);
      check("both.instr", 32'(bus.instruction), 32'd0);
      check("both.ready", 32'(bus.loadReady), 32'd1);

      // Asynchronous reset mid-word
      send_byte(8'h12); send_byte(8'h34);
      @(negedge clock);
      resetN = 1'b0;
      #1;
      model_reset();
      check_outputs("asyncrst");
      @(negedge clock);
      resetN = 1'b1;
      pulse_end();
      fetch(16'd0);
      check("asyncrst.fetch", 32'(bus.instrValid), 32'd0);

      // Randomized loads and fetches
      for (int r = 0; r < 25; r++) begin
         pulse_start();
         nb = int'($urandom_range(0, 48));
         for (int i = 0; i < nb; i++) begin
            bus.loadValid = 1'b1;
            bus.loadByte  = 8'($urandom);
            bus.loadEnd   = (i == nb - 1) && ($urandom_range(0, 1) == 1);
            step("rnd.byte");
            idle_inputs();
            if ($urandom_range(0, 3) == 0) step("rnd.gap");
         end
         if (!bus.running) pulse_end();
         for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 4) == 0)
               bus.instructionPointer = 16'($urandom);
            else
               bus.instructionPointer = 16'($urandom_range(0, 15));
            bus.loadEnd = ($urandom_range(0, 7) == 0);
            step("rnd.fetch");
            bus.loadEnd = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
